pulse_burst_ctrl: RTL and testbench

- Sequencer for the pulse_gen datapath. Owns its `run`/`period`/`width` inputs and observes its `pulse_out`.
- Accepts a validated burst configuration over a valid/ready port.
- Arms on command, starts on a trigger edge, counts N complete pulses, then stops the generator cleanly and reports done.
- Sits between the host register bank and one pulse_gen instance.

---
 rtl/pulse_burst_ctrl_pkg.sv | 20 ++
 rtl/pulse_burst_edge.sv | 58 +++++
 rtl/pulse_burst_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pulse_burst_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_burst_ctrl_pkg.sv
// pulse_burst_ctrl_pkg
// Shared definitions for the pulse burst sequencer and the pulse_gen instance
// it drives: state encoding, default field widths and the minimum legal period.
// No ports.

package pulse_burst_ctrl_pkg;

    localparam int PBC_COUNT_WIDTH = 32;
    localparam int PBC_BURST_WIDTH = 16;

    // A period of 1 leaves no room for both a high and a low phase.
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_burst_edge.sv
// pulse_burst_edge
// Registers a single-bit signal and reports its rising and falling edges.
// With SYNC_EN set, the input first passes through a two-flop synchronizer,
// so an asynchronous input can be edge-detected safely.
//
// Ports:
//   clk   in   system clock
//   reset in   synchronous active-high reset; clears every flop
//   sig   in   signal to observe
//   rise  out  sampled signal is 1 now and was 0 last cycle
//   fall  out  sampled signal is 0 now and was 1 last cycle

module pulse_burst_edge #(
    parameter bit SYNC_EN = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sampled;
    logic sig_q;

    generate
        if (SYNC_EN) begin : g_sync
            logic sync_1;
            logic sync_2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_1 <= 1'b0;
                    sync_2 <= 1'b0;
                end else begin
                    sync_1 <= sig;
                    sync_2 <= sync_1;
                end
            end

            assign sampled = sync_2;
        end else begin : g_direct
            assign sampled = sig;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sampled;
        end
    end

    assign rise = sampled & ~sig_q;
    assign fall = sig_q & ~sampled;

endmodule

// File: rtl/pulse_burst_ctrl.sv
// pulse_burst_ctrl
// Sequencer for one pulse_gen instance. Accepts a validated burst
// configuration, arms on request, starts on a trigger rising edge, counts
// completed pulses (falling edges of gen_pulse) and stops the generator after
// the requested number of pulses, pulsing done. A count of 0 runs until abort.
//
// Build option: define PULSE_BURST_TRIG_SYNC_EN to put a two-flop synchronizer
// on trig (trigger-to-gen_run latency grows from 1 to 3 cycles).
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   cfg_valid/cfg_ready        config handshake; ready iff state is IDLE
//   cfg_period/width/count     burst configuration (count 0 = continuous)
//   arm, abort, trig           control: arm level, immediate stop, start edge
//   gen_run/period/width       drive the pulse_gen instance
//   gen_pulse                  pulse_gen output, observed for completed pulses
//   busy                       ARMED or RUN
//   done, cfg_err              one-cycle status pulses
//   pulse_cnt                  pulses completed in the current or last burst
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for config / arm; config port open
// ARMED | config frozen, waiting for a trigger rising edge
// RUN   | gen_run high, counting falling edges of gen_pulse

module pulse_burst_ctrl
    import pulse_burst_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = PBC_COUNT_WIDTH,
    parameter int BURST_WIDTH = PBC_BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [COUNT_WIDTH-1:0] cfg_period,
    input  logic [COUNT_WIDTH-1:0] cfg_width,
    input  logic [BURST_WIDTH-1:0] cfg_count,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trig,
    output logic                   gen_run,
    output logic [COUNT_WIDTH-1:0] gen_period,
    output logic [COUNT_WIDTH-1:0] gen_width,
    input  logic                   gen_pulse,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic [BURST_WIDTH-1:0] pulse_cnt
);

`ifdef PULSE_BURST_TRIG_SYNC_EN
    localparam bit TRIG_SYNC = 1'b1;
`else
    localparam bit TRIG_SYNC = 1'b0;
`endif

    state_t                 state, state_n;
    logic                   loaded, loaded_n;
    logic [COUNT_WIDTH-1:0] period_n, width_n;
    logic [BURST_WIDTH-1:0] count_q, count_n;
    logic                   run_n, done_n, err_n;
    logic [BURST_WIDTH-1:0] cnt_n, cnt_inc;

    logic trig_rise, trig_fall;
    logic pulse_rise, pulse_fall;
    logic cfg_acc, cfg_legal, arm_eff;
    logic unused_edges;

    pulse_burst_edge #(.SYNC_EN(TRIG_SYNC)) u_trig_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (trig),
        .rise  (trig_rise),
        .fall  (trig_fall)
    );

    pulse_burst_edge #(.SYNC_EN(1'b0)) u_pulse_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (gen_pulse),
        .rise  (pulse_rise),
        .fall  (pulse_fall)
    );

    assign unused_edges = trig_fall | pulse_rise;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state == ARMED) || (state == RUN);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign cfg_legal = (cfg_period >= COUNT_WIDTH'(MIN_PERIOD)) &&
                       (cfg_width != '0) && (cfg_width < cfg_period);
    // abort outranks arm, so an aborted arm neither arms nor flags an error
    assign arm_eff   = arm && !abort;
    assign cnt_inc   = pulse_cnt + BURST_WIDTH'(1);

    always_comb begin
        state_n  = state;
        loaded_n = loaded;
        period_n = gen_period;
        width_n  = gen_width;
        count_n  = count_q;
        run_n    = gen_run;
        done_n   = 1'b0;
        err_n    = 1'b0;
        cnt_n    = pulse_cnt;

        case (state)
            IDLE: begin
                if (cfg_acc) begin
                    if (cfg_legal) begin
                        period_n = cfg_period;
                        width_n  = cfg_width;
                        count_n  = cfg_count;
                        loaded_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                // a legal config offered in the same cycle counts as loaded
                if (arm_eff) begin
                    if (loaded || (cfg_acc && cfg_legal)) begin
                        state_n = ARMED;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (trig_rise) begin
                    state_n = RUN;
                    run_n   = 1'b1;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                if (pulse_fall) begin
                    if (pulse_cnt != '1) begin
                        cnt_n = cnt_inc;
                    end
                    if ((count_q != '0) && (cnt_inc == count_q)) begin
                        state_n = IDLE;
                        run_n   = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                run_n   = 1'b0;
            end
        endcase

        if (abort) begin
            state_n = IDLE;
            run_n   = 1'b0;
            done_n  = 1'b0;
            cnt_n   = pulse_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            loaded     <= 1'b0;
            gen_period <= '0;
            gen_width  <= '0;
            count_q    <= '0;
            gen_run    <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            state      <= state_n;
            loaded     <= loaded_n;
            gen_period <= period_n;
            gen_width  <= width_n;
            count_q    <= count_n;
            gen_run    <= run_n;
            done       <= done_n;
            cfg_err    <= err_n;
            pulse_cnt  <= cnt_n;
        end
    end

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// tb_pulse_burst_ctrl
// Self-checking bench for pulse_burst_ctrl. A small behavioural pulse_gen
// stands in for the real generator. Checks: reset state, a config validation
// table, the basic burst waveform, abort, continuous mode, ignored inputs,
// reset mid-run and randomized bursts against closed-form timing.

module tb_pulse_burst_ctrl;

    localparam int CW = 32;
    localparam int BW = 16;
`ifdef PULSE_BURST_TRIG_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_period = '0;
    logic [CW-1:0] cfg_width = '0;
    logic [BW-1:0] cfg_count = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trig = 1'b0;
    logic          gen_run;
    logic [CW-1:0] gen_period;
    logic [CW-1:0] gen_width;
    logic          gen_pulse;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [BW-1:0] pulse_cnt;

    always #5 clk = ~clk;

    pulse_burst_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_width  (cfg_width),
        .cfg_count  (cfg_count),
        .arm        (arm),
        .abort      (abort),
        .trig       (trig),
        .gen_run    (gen_run),
        .gen_period (gen_period),
        .gen_width  (gen_width),
        .gen_pulse  (gen_pulse),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .pulse_cnt  (pulse_cnt)
    );

    // Behavioural pulse_gen: first high cycle one cycle after run rises,
    // high for width cycles out of every period.
    logic [CW-1:0] pg_cnt;
    always_ff @(posedge clk) begin
        if (reset || !gen_run) begin
            pg_cnt    <= '0;
            gen_pulse <= 1'b0;
        end else begin
            gen_pulse <= (pg_cnt < gen_width);
            pg_cnt    <= (pg_cnt >= gen_period - 1) ? '0 : pg_cnt + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cfg_valid = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic send_cfg(input logic [CW-1:0] p, input logic [CW-1:0] w, input logic [BW-1:0] c,
                            input bit with_arm);
        cfg_valid = 1'b1; cfg_period = p; cfg_width = w; cfg_count = c; arm = with_arm;
        tick();
        cfg_valid = 1'b0; arm = 1'b0;
    endtask

    task automatic start_burst(input logic [CW-1:0] p, input logic [CW-1:0] w, input logic [BW-1:0] c);
        send_cfg(p, w, c, 1'b0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    // Called in the cycle after the trigger cycle (k=1); returns k of done.
    task automatic wait_done(input int bound, output int k_done, output int run_cycles, output bit ok);
        int k;
        k = 1; ok = 1'b0; run_cycles = 0; k_done = 0;
        while (k <= bound && !ok) begin
            if (done) begin
                ok = 1'b1;
                k_done = k;
            end else begin
                if (gen_run) run_cycles++;
                tick();
                k++;
            end
        end
    endtask

    typedef struct {
        logic [CW-1:0] period;
        logic [CW-1:0] width;
        logic          exp_err;
        logic [CW-1:0] exp_period;
        logic [CW-1:0] exp_width;
    } cfg_vec_t;

    cfg_vec_t vecs[10];

    task automatic apply_vec(input int i);
        send_cfg(vecs[i].period, vecs[i].width, 16'd1, 1'b0);
        check($sformatf("vec%0d_err", i), cfg_err, vecs[i].exp_err);
        check($sformatf("vec%0d_period", i), gen_period, vecs[i].exp_period);
        check($sformatf("vec%0d_width", i), gen_width, vecs[i].exp_width);
        check($sformatf("vec%0d_ready", i), cfg_ready, 1'b1);
        tick();
        check($sformatf("vec%0d_err_clr", i), cfg_err, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k_done, run_cycles, dn, seen, k, pc;
        bit ok, prev;

        vecs[0] = '{32'd5, 32'd5, 1'b1, 32'd0, 32'd0};
        vecs[1] = '{32'd1, 32'd0, 1'b1, 32'd0, 32'd0};
        vecs[2] = '{32'd6, 32'd0, 1'b1, 32'd0, 32'd0};
        vecs[3] = '{32'd7, 32'd3, 1'b0, 32'd7, 32'd3};
        vecs[4] = '{32'd4, 32'd4, 1'b1, 32'd7, 32'd3};
        vecs[5] = '{32'd2, 32'd1, 1'b0, 32'd2, 32'd1};
        vecs[6] = '{32'd0, 32'd0, 1'b1, 32'd2, 32'd1};
        vecs[7] = '{32'd10, 32'd9, 1'b0, 32'd10, 32'd9};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[9] = '{32'd3, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

        // reset state
        do_reset();
        check("rst_run", gen_run, 1'b0);
        check("rst_period", gen_period, 32'd0);
        check("rst_width", gen_width, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_cnt", pulse_cnt, 16'd0);
        check("rst_ready", cfg_ready, 1'b1);
        check("rst_busy", busy, 1'b0);

        // config validation table; arm with nothing loaded after the illegal ones
        for (int i = 0; i < 3; i++) apply_vec(i);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_unloaded_err", cfg_err, 1'b1);
        check("arm_unloaded_busy", busy, 1'b0);
        tick();
        check("arm_unloaded_err_clr", cfg_err, 1'b0);
        for (int i = 3; i < 10; i++) apply_vec(i);

        // basic burst: period 5, width 2, count 3
        do_reset();
        send_cfg(32'd5, 32'd2, 16'd3, 1'b0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("basic_armed", busy, 1'b1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int kk = 1; kk <= 16; kk++) begin
            int r;
            r = kk - (LAT - 1);
            check($sformatf("basic_run@%0d", kk), gen_run, (r >= 1 && r <= 14));
            check($sformatf("basic_pulse@%0d", kk), gen_pulse,
                  (r == 2 || r == 3 || r == 7 || r == 8 || r == 12 || r == 13));
            check($sformatf("basic_done@%0d", kk), done, (r == 15));
            if (r == 15) check("basic_cnt_at_done", pulse_cnt, 16'd3);
            tick();
        end
        check("basic_cnt", pulse_cnt, 16'd3);
        check("basic_ready", cfg_ready, 1'b1);
        check("basic_busy", busy, 1'b0);
        repeat (5) tick();
        check("basic_cnt_hold", pulse_cnt, 16'd3);

        // reset mid-run
        do_reset();
        start_burst(32'd5, 32'd2, 16'd3);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_run", gen_run, 1'b0);
        check("midrst_period", gen_period, 32'd0);
        check("midrst_width", gen_width, 32'd0);
        check("midrst_cnt", pulse_cnt, 16'd0);
        check("midrst_done", done, 1'b0);
        check("midrst_ready", cfg_ready, 1'b1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("midrst_unloaded_err", cfg_err, 1'b1);
        check("midrst_unloaded_busy", busy, 1'b0);

        // abort during the second pulse's high phase
        do_reset();
        start_burst(32'd8, 32'd4, 16'd10);
        seen = 0; prev = 1'b0; k = 0;
        while (seen < 2 && k < 100) begin
            if (gen_pulse && !prev) seen++;
            prev = gen_pulse;
            if (seen < 2) begin
                tick();
                k++;
            end
        end
        check("abort_found_pulse2", (seen == 2), 1'b1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_run", gen_run, 1'b0);
        check("abort_cnt", pulse_cnt, 16'd1);
        check("abort_ready", cfg_ready, 1'b1);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dn++;
            tick();
        end
        check("abort_no_done", dn, 0);
        check("abort_cnt_hold", pulse_cnt, 16'd1);

        // continuous mode
        do_reset();
        start_burst(32'd3, 32'd1, 16'd0);
        dn = 0;
        for (int i = 0; i < 300; i++) begin
            if (done) dn++;
            tick();
        end
        pc = int'(pulse_cnt);
        check("cont_no_done", dn, 0);
        check("cont_running", gen_run, 1'b1);
        if (pc < 99 || pc > 101) $display("FAIL cont_count actual=%0d required=99..101", pc);
        check("cont_count_in_range", (pc >= 99 && pc <= 101), 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("cont_abort_run", gen_run, 1'b0);
        check("cont_abort_busy", busy, 1'b0);

        // ignored inputs during RUN: config offer, second trigger
        do_reset();
        start_burst(32'd6, 32'd2, 16'd4);
        repeat (5) tick();
        check("ign_cnt_k6", pulse_cnt, 16'd1);
        cfg_valid = 1'b1; cfg_period = 32'd9; cfg_width = 32'd3; cfg_count = 16'd1;
        check("ign_ready_low", cfg_ready, 1'b0);
        tick(); tick();
        cfg_valid = 1'b0;
        check("ign_period", gen_period, 32'd6);
        check("ign_width", gen_width, 32'd2);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("ign_retrig_run", gen_run, 1'b1);
        check("ign_retrig_cnt", pulse_cnt, 16'd1);
        wait_done(40, k_done, run_cycles, ok);
        check("ign_done_seen", ok, 1'b1);
        // done expected at k = 3 + (N-1)*P + W relative to the first trigger (k=9 now)
        check("ign_done_time", k_done + 8, 3 + 3 * 6 + 2 + (LAT - 1));
        check("ign_done_cnt", pulse_cnt, 16'd4);

        // abort and trigger in the same cycle while ARMED
        do_reset();
        send_cfg(32'd4, 32'd2, 16'd2, 1'b0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b1; trig = 1'b1;
        tick();
        abort = 1'b0; trig = 1'b0;
        check("abtrig_busy", busy, 1'b0);
        repeat (LAT + 1) tick();
        check("abtrig_run", gen_run, 1'b0);
        check("abtrig_ready", cfg_ready, 1'b1);

        // randomized bursts against the closed-form timing model
        do_reset();
        begin
            logic [CW-1:0] m_period, m_width;
            bit            m_loaded;
            m_period = '0; m_width = '0; m_loaded = 1'b0;
            for (int it = 0; it < 40; it++) begin
                int p, w, c, dly;
                bit same_arm, legal, exp_busy;
                p = $urandom_range(0, 7);
                w = $urandom_range(0, 7);
                c = $urandom_range(1, 4);
                same_arm = $urandom_range(0, 1);
                legal = (p >= 2) && (w >= 1) && (w < p);
                exp_busy = same_arm && (legal || m_loaded);
                send_cfg(CW'(p), CW'(w), BW'(c), same_arm);
                if (legal) begin
                    m_period = CW'(p); m_width = CW'(w); m_loaded = 1'b1;
                end
                check($sformatf("rnd%0d_err", it), cfg_err, !legal || (same_arm && !exp_busy));
                check($sformatf("rnd%0d_period", it), gen_period, m_period);
                check($sformatf("rnd%0d_width", it), gen_width, m_width);
                check($sformatf("rnd%0d_busy", it), busy, exp_busy);
                if (legal) begin
                    if (!same_arm) begin
                        arm = 1'b1;
                        tick();
                        arm = 1'b0;
                    end
                    dly = $urandom_range(0, 4);
                    repeat (dly) tick();
                    trig = 1'b1;
                    tick();
                    trig = 1'b0;
                    wait_done(200, k_done, run_cycles, ok);
                    check($sformatf("rnd%0d_done_seen", it), ok, 1'b1);
                    check($sformatf("rnd%0d_done_k", it), k_done, LAT + 2 + (c - 1) * p + w);
                    check($sformatf("rnd%0d_run_len", it), run_cycles, 2 + (c - 1) * p + w);
                    check($sformatf("rnd%0d_cnt", it), pulse_cnt, BW'(c));
                    tick();
                    check($sformatf("rnd%0d_idle_run", it), gen_run, 1'b0);
                end else if (exp_busy) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                end
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
